// File: rtl/pwm_pkg.sv
// Shared constants, duty type and soft-ramp step helper for the multi-channel PWM.
package pwm_pkg;

   localparam int unsigned CNT_W_DEF  = 16;
   localparam int unsigned PERIOD_DEF = 24000;

   typedef logic [CNT_W_DEF-1:0] duty_t;

   // Move active toward target by at most step; callers zero-extend narrower duties.
   function automatic logic [31:0] ramp_next(input logic [31:0] active,
                                             input logic [31:0] target,
                                             input logic [31:0] step);
      logic [31:0] diff;
      if (target >= active) begin
         diff      = target - active;
         ramp_next = (diff <= step) ? target : active + step;
      end else begin
         diff      = active - target;
         ramp_next = (diff <= step) ? target : active - step;
      end
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM compare channel: shadow/active duty, period-boundary load, registered output.
// Optional soft ramp of the active duty under PWM_SOFT_RAMP_EN.
module pwm_channel
   import pwm_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned RAMP_STEP = 64
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_load,
   input  logic             i_wr,
   input  logic [CNT_W-1:0] i_wr_duty,
   input  logic [CNT_W-1:0] i_cnt,
   output logic             o_pwm,
   output logic [CNT_W-1:0] o_active
);

`ifdef PWM_SOFT_RAMP_EN
   localparam bit RAMP_EN = 1'b1;
`else
   localparam bit RAMP_EN = 1'b0;
`endif

   // An all-ones step makes ramp_next hand back the shadow value unchanged.
   localparam logic [31:0] STEP = RAMP_EN ? 32'(RAMP_STEP) : '1;

   logic [CNT_W-1:0] r_shadow;
   logic [CNT_W-1:0] r_active;
   logic             r_pwm;
   logic [CNT_W-1:0] w_next;

   assign w_next = CNT_W'(ramp_next(32'(r_active), 32'(r_shadow), STEP));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_shadow <= '0;
         r_active <= '0;
         r_pwm    <= 1'b0;
      end else begin
         if (i_wr) begin
            r_shadow <= i_wr_duty;
         end
         if (i_load) begin
            r_active <= w_next;
         end
         r_pwm <= i_en && (i_cnt < r_active);
      end
   end

   assign o_pwm    = r_pwm;
   assign o_active = r_active;

endmodule

// File: rtl/pwm_multichannel_gen.sv
// Multi-channel PWM generator: shared period counter, write decode, period_start pulse.
// Soft duty ramping per channel is enabled with PWM_SOFT_RAMP_EN.
module pwm_multichannel_gen
   import pwm_pkg::*;
#(
   parameter int unsigned N_CH      = 4,
   parameter int unsigned CNT_W     = CNT_W_DEF,
   parameter int unsigned PERIOD    = PERIOD_DEF,
   parameter int unsigned RAMP_STEP = 64
) (
   input  logic                                       CLK,
   input  logic                                       Reset,
   input  logic                                       en,
   input  logic                                       wr_en,
   input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] wr_ch,
   input  logic [CNT_W-1:0]                           wr_duty,
   output logic                                       period_start,
   output logic [N_CH-1:0]                            pwm_out,
   output logic [N_CH*CNT_W-1:0]                      duty_active
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_period_start;
   logic             w_load;
   logic [N_CH-1:0]  w_wr;

   assign w_load = en && (r_cnt == LAST);

   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_cnt          <= '0;
         r_period_start <= 1'b0;
      end else begin
         r_period_start <= en && (r_cnt == '0);
         if (en) begin
            r_cnt <= w_load ? '0 : r_cnt + CNT_W'(1);
         end
      end
   end

   assign period_start = r_period_start;

   // Out-of-range channel indices match no decode line and are dropped.
   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      assign w_wr[g] = wr_en && (32'(wr_ch) == g);

      pwm_channel #(
         .CNT_W     (CNT_W),
         .RAMP_STEP (RAMP_STEP)
      ) u_ch (
         .i_clk     (CLK),
         .i_rst     (Reset),
         .i_en      (en),
         .i_load    (w_load),
         .i_wr      (w_wr[g]),
         .i_wr_duty (wr_duty),
         .i_cnt     (r_cnt),
         .o_pwm     (pwm_out[g]),
         .o_active  (duty_active[g*CNT_W +: CNT_W])
      );
   end

endmodule
